// File: rtl/fix_session_pkg.sv
// fix_session_pkg: event and heartbeat-state types shared by the FIX session blocks
package fix_session_pkg;
  typedef enum logic [1:0] {
    EVT_NONE       = 2'b00,
    EVT_TEST_REQ   = 2'b01,
    EVT_DISCONNECT = 2'b10
  } evt_type_t;
  typedef enum logic [1:0] {
    HB_IDLE,
    HB_ACTIVE,
    HB_TEST_SENT,
    HB_DEAD
  } hb_state_t;
endpackage

// File: rtl/fix_hb_rx_monitor_tracker.sv
// fix_hb_host_tracker: per-host heartbeat FSM, tick counter and pending event
module fix_hb_host_tracker
  import fix_session_pkg::*;
#(
  parameter int CNT_SIZE = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              rx,
  input  logic              logon,
  input  logic              logoff,
  input  logic              load,
  input  logic              hb_en,
  input  logic [CNT_SIZE:0] thr,
  output logic              pend,
  output evt_type_t         pend_type,
  output logic              active,
  output logic              dead
);
  hb_state_t         st, st_n;
  logic [CNT_SIZE:0] cnt, cnt_n, cnt_inc;
  logic              pend_n, hit;
  evt_type_t         type_n;
  assign hit     = hb_en && cnt == thr;
  assign cnt_inc = (tick && !(&cnt)) ? cnt + 1'b1 : cnt;
  // next state: logoff > logon > rx > timeout; a loaded event clears pending
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    pend_n = pend & ~load;
    type_n = pend_type;
    if (logoff) begin
      st_n   = HB_IDLE;
      cnt_n  = '0;
      pend_n = 1'b0;
    end else if (logon) begin
      st_n  = HB_ACTIVE;
      cnt_n = '0;
    end else if (st == HB_ACTIVE || st == HB_TEST_SENT) begin
      if (rx) begin
        st_n  = HB_ACTIVE;
        cnt_n = '0;
        if (st == HB_TEST_SENT) pend_n = 1'b0;
      end else if (hit) begin
        st_n   = (st == HB_ACTIVE) ? HB_TEST_SENT : HB_DEAD;
        cnt_n  = (st == HB_ACTIVE) ? '0 : cnt;
        pend_n = 1'b1;
        type_n = (st == HB_ACTIVE) ? EVT_TEST_REQ : EVT_DISCONNECT;
      end else begin
        cnt_n = cnt_inc;
      end
    end
  end
  // state registers; status flags trail the state by one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= HB_IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      pend_type <= EVT_NONE;
      active    <= 1'b0;
      dead      <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      pend      <= pend_n;
      pend_type <= type_n;
      active    <= st == HB_ACTIVE || st == HB_TEST_SENT;
      dead      <= st == HB_DEAD;
    end
  end
endmodule

// File: rtl/fix_hb_rx_monitor.sv
// fix_hb_rx_monitor: receive-side heartbeat supervisor with round-robin event output
module fix_hb_rx_monitor
  import fix_session_pkg::*;
#(
  parameter int CNT_SIZE    = 20,
  parameter int NUM_HOST    = 4,
  parameter int HOST_W      = 2,
  parameter int GRACE_TICKS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_i,
  input  logic [CNT_SIZE-1:0] heartbeat_i,
  input  logic                rx_valid_i,
  input  logic [HOST_W-1:0]   rx_host_i,
  input  logic                logon_i,
  input  logic                logoff_i,
  input  logic [HOST_W-1:0]   ctl_host_i,
  output logic                evt_valid_o,
  output logic [1:0]          evt_type_o,
  output logic [HOST_W-1:0]   evt_host_o,
  input  logic                evt_ready_i,
  output logic [NUM_HOST-1:0] active_mask_o,
  output logic [NUM_HOST-1:0] dead_mask_o
);
  logic [CNT_SIZE:0]   thr;
  logic [NUM_HOST-1:0] pend, load;
  evt_type_t           pend_type [NUM_HOST];
  logic [HOST_W-1:0]   rr, win;
  logic                win_v, ld;
  assign thr = {1'b0, heartbeat_i} + (CNT_SIZE + 1)'(GRACE_TICKS);
  for (genvar h = 0; h < NUM_HOST; h++) begin : g_host
    fix_hb_host_tracker #(.CNT_SIZE(CNT_SIZE)) u_trk (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick_i),
      .rx        (rx_valid_i && rx_host_i == HOST_W'(h)),
      .logon     (logon_i && ctl_host_i == HOST_W'(h)),
      .logoff    (logoff_i && ctl_host_i == HOST_W'(h)),
      .load      (load[h]),
      .hb_en     (heartbeat_i != '0),
      .thr       (thr),
      .pend      (pend[h]),
      .pend_type (pend_type[h]),
      .active    (active_mask_o[h]),
      .dead      (dead_mask_o[h])
    );
  end
  // round-robin pick: scan downward so the host nearest rr wins
  always_comb begin
    win   = '0;
    win_v = 1'b0;
    for (int i = NUM_HOST - 1; i >= 0; i--) begin
      if (pend[HOST_W'((int'(rr) + i) % NUM_HOST)]) begin
        win   = HOST_W'((int'(rr) + i) % NUM_HOST);
        win_v = 1'b1;
      end
    end
    ld   = win_v && (!evt_valid_o || evt_ready_i);
    load = ld ? NUM_HOST'(1) << win : '0;
  end
  // output register: loads when empty or on the accept edge, otherwise holds
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_o <= 1'b0;
      evt_type_o  <= EVT_NONE;
      evt_host_o  <= '0;
      rr          <= '0;
    end else begin
      if (evt_valid_o && evt_ready_i)
        rr <= (evt_host_o == HOST_W'(NUM_HOST - 1)) ? '0 : evt_host_o + 1'b1;
      if (ld) begin
        evt_valid_o <= 1'b1;
        evt_type_o  <= pend_type[win];
        evt_host_o  <= win;
      end else if (evt_ready_i) begin
        evt_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fix_hb_rx_monitor.sv
// tb_fix_hb_rx_monitor: directed stimulus with a queued scoreboard for output events
module tb_fix_hb_rx_monitor;
  logic        clk = 1'b0;
  logic        rst, tick_i, rx_valid_i, logon_i, logoff_i, evt_ready_i;
  logic [19:0] heartbeat_i;
  logic [1:0]  rx_host_i, ctl_host_i, evt_type_o, evt_host_o;
  logic        evt_valid_o;
  logic [3:0]  active_mask_o, dead_mask_o;
  typedef struct { logic [1:0] t; logic [1:0] h; } exp_t;
  exp_t exp_q[$];
  int vectors = 0;
  int miss = 0;
  fix_hb_rx_monitor #(.CNT_SIZE(20), .NUM_HOST(4), .HOST_W(2), .GRACE_TICKS(1)) dut (
    .clk(clk), .rst(rst), .tick_i(tick_i), .heartbeat_i(heartbeat_i),
    .rx_valid_i(rx_valid_i), .rx_host_i(rx_host_i), .logon_i(logon_i),
    .logoff_i(logoff_i), .ctl_host_i(ctl_host_i), .evt_valid_o(evt_valid_o),
    .evt_type_o(evt_type_o), .evt_host_o(evt_host_o), .evt_ready_i(evt_ready_i),
    .active_mask_o(active_mask_o), .dead_mask_o(dead_mask_o)
  );
  always #5 clk = ~clk;
  // monitor: every accepted event must match the head of the expected queue
  always @(negedge clk) begin
    if (evt_valid_o && evt_ready_i) begin
      exp_t e;
      vectors++;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL evt_unexpected: got type=%0d host=%0d, required no event", evt_type_o, evt_host_o);
      end else begin
        e = exp_q.pop_front();
        if (evt_type_o !== e.t || evt_host_o !== e.h) begin
          miss++;
          $display("FAIL evt_order: got type=%0d host=%0d, required type=%0d host=%0d", evt_type_o, evt_host_o, e.t, e.h);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, required completion");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      tick_i = 1'b1;
      cyc(1);
      tick_i = 1'b0;
      cyc(2);
    end
  endtask
  task automatic logon(input logic [1:0] h);
    logon_i = 1'b1;
    ctl_host_i = h;
    cyc(1);
    logon_i = 1'b0;
  endtask
  task automatic rx(input logic [1:0] h);
    rx_valid_i = 1'b1;
    rx_host_i = h;
    cyc(1);
    rx_valid_i = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
  endtask
  initial begin
    {tick_i, rx_valid_i, logon_i, logoff_i, rx_host_i, ctl_host_i} = '0;
    heartbeat_i = 20'd4;
    evt_ready_i = 1'b1;
    rst = 1'b1;
    cyc(3);
    chk("rst_valid", evt_valid_o, 0);
    chk("rst_type", evt_type_o, 0);
    chk("rst_host", evt_host_o, 0);
    chk("rst_active", active_mask_o, 0);
    chk("rst_dead", dead_mask_o, 0);
    rst = 1'b0;
    ticks(8);
    logon(2'd1);
    cyc(2);
    chk("h1_active_logon", active_mask_o, 4'b0010);
    ticks(4);
    exp_q.push_back('{2'b01, 2'd1});
    ticks(1);
    cyc(2);
    chk("h1_active_testsent", active_mask_o, 4'b0010);
    ticks(4);
    exp_q.push_back('{2'b10, 2'd1});
    ticks(1);
    cyc(2);
    chk("h1_dead", dead_mask_o, 4'b0010);
    chk("h1_not_active", active_mask_o, 4'b0000);
    chk("h1_queue_drained", exp_q.size(), 0);
    do_reset();
    logon(2'd0);
    repeat (15) begin
      ticks(4);
      rx(2'd0);
    end
    chk("keepalive_active", active_mask_o, 4'b0001);
    chk("keepalive_dead", dead_mask_o, 4'b0000);
    do_reset();
    logon(2'd0);
    logon(2'd2);
    logon(2'd3);
    ticks(4);
    evt_ready_i = 1'b0;
    ticks(1);
    repeat (10) begin
      chk("hold_valid", evt_valid_o, 1);
      chk("hold_type", evt_type_o, 2'b01);
      chk("hold_host", evt_host_o, 0);
      cyc(1);
    end
    exp_q.push_back('{2'b01, 2'd0});
    exp_q.push_back('{2'b01, 2'd2});
    exp_q.push_back('{2'b01, 2'd3});
    evt_ready_i = 1'b1;
    cyc(3);
    chk("simul_drained_3cyc", exp_q.size(), 0);
    chk("simul_active", active_mask_o, 4'b1101);
    do_reset();
    logon(2'd2);
    ticks(4);
    exp_q.push_back('{2'b01, 2'd2});
    ticks(1);
    cyc(2);
    ticks(4);
    tick_i = 1'b1;
    rx_valid_i = 1'b1;
    rx_host_i = 2'd2;
    cyc(1);
    tick_i = 1'b0;
    rx_valid_i = 1'b0;
    cyc(2);
    chk("race_active", active_mask_o, 4'b0100);
    chk("race_dead", dead_mask_o, 4'b0000);
    ticks(4);
    cyc(3);
    chk("race_no_disconnect", exp_q.size(), 0);
    chk("race_still_active", active_mask_o, 4'b0100);
    do_reset();
    heartbeat_i = 20'd0;
    logon(2'd3);
    ticks(100);
    cyc(3);
    chk("disable_active", active_mask_o, 4'b1000);
    chk("disable_no_evt", evt_valid_o, 0);
    heartbeat_i = 20'd4;
    logon(2'd3);
    evt_ready_i = 1'b0;
    ticks(5);
    cyc(2);
    chk("pre_rst_valid", evt_valid_o, 1);
    chk("pre_rst_host", evt_host_o, 3);
    rst = 1'b1;
    cyc(1);
    chk("midrst_valid", evt_valid_o, 0);
    chk("midrst_active", active_mask_o, 0);
    chk("midrst_dead", dead_mask_o, 0);
    cyc(2);
    rst = 1'b0;
    evt_ready_i = 1'b1;
    cyc(6);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule

// File: doc/fix_hb_rx_monitor.md
# fix_hb_rx_monitor

Receive-side heartbeat supervisor for the FIX session layer. For each remote host it counts heartbeat ticks since the last inbound message. On the first timeout it requests a TestRequest. On a second, unanswered timeout it requests a disconnect. Events go to the session/message-builder logic over a valid/ready channel; the block pairs with the transmit-side heartbeat counter.

## Interface
- CNT_SIZE, 20, tick-counter base width (heartbeat interval width)
- NUM_HOST, 4, number of tracked hosts
- HOST_W, 2, host address width, $clog2(NUM_HOST)
- GRACE_TICKS, 1, transmission allowance added to heartbeat interval
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- tick_i  in  1  one-cycle heartbeat time-base strobe (prescaled seconds)
- heartbeat_i  in  CNT_SIZE  negotiated HeartBtInt in ticks; 0 disables timeouts
- rx_valid_i  in  1  a complete, valid inbound message was parsed
- rx_host_i  in  HOST_W  source host of that message
- logon_i  in  1  session established for ctl_host_i
- logoff_i  in  1  session closed for ctl_host_i
- ctl_host_i  in  HOST_W  host addressed by logon_i/logoff_i
- evt_valid_o  out  1  event available
- evt_type_o  out  2  01 = TEST_REQ, 10 = DISCONNECT
- evt_host_o  out  HOST_W  host the event concerns
- evt_ready_i  in  1  consumer accepts event
- active_mask_o  out  NUM_HOST  host in ACTIVE or TEST_SENT
- dead_mask_o  out  NUM_HOST  host in DEAD

## Operation
- Per-host state machine: IDLE, ACTIVE, TEST_SENT, DEAD. Each host has a counter of CNT_SIZE+1 bits.
- Threshold T = heartbeat_i + GRACE_TICKS, computed at CNT_SIZE+1 bits. It never overflows.
- IDLE:
  - counter held at 0.
  - logon → ACTIVE, counter 0.
- ACTIVE:
  - tick_i increments the counter, saturating at all-ones.
  - rx for this host clears the counter to 0. Clear wins over a same-cycle tick.
  - counter == T and heartbeat_i != 0 → TEST_SENT, counter 0, pending = TEST_REQ.
- TEST_SENT:
  - tick_i counts as in ACTIVE.
  - rx → ACTIVE, counter 0. Any message counts as a reply.
  - rx also cancels a pending TEST_REQ that has not yet been loaded into the output register.
  - counter == T → DEAD, pending = DISCONNECT. This overwrites an unissued TEST_REQ.
- DEAD:
  - counter held.
  - logon → ACTIVE.
  - logoff → IDLE.
  - rx ignored.
- logoff in any state → IDLE, counter 0, pending cleared.
- Same-host, same-cycle priority: logoff > logon > rx > timeout.
- heartbeat_i == 0: counters still run; no timeout fires.
- Arbiter:
  - Round-robin over pending flags, starting at pointer rr.
  - The winner is loaded into the output register when it is empty, or in the cycle it is being accepted.
  - The winner's pending flag clears on load.
  - After each accept, rr becomes the accepted host + 1, mod NUM_HOST.
- A loaded event is committed. It is not withdrawn or altered by later rx/logoff until accepted.

## Timing
- Reset values:
  - evt_valid_o = 0, evt_type_o = 00, evt_host_o = 0.
  - active_mask_o = 0, dead_mask_o = 0.
  - All hosts IDLE, counters 0, pending 0, rr = 0.
- Reset mid-handshake drops evt_valid_o in the next cycle; the event is lost.
- Counter reaches T at edge k. The state transition and pending set happen at edge k+1. evt_valid_o rises at edge k+2 if the output register is free.
- Handshake:
  - Transfer occurs when evt_valid_o && evt_ready_i at a clock edge.
  - evt_type_o and evt_host_o are stable while valid && !ready.
  - Back-to-back events are possible: a new event loads on the accept edge.
- active_mask_o and dead_mask_o are registered. They reflect state one edge after the transition.
- rx_valid_i and logon_i/logoff_i are sampled on every edge; each has a single-cycle effect.

## Structure
- Package fix_session_pkg:
  - evt_type_t enum (EVT_NONE = 00, EVT_TEST_REQ = 01, EVT_DISCONNECT = 10).
  - hb_state_t enum.
  - Shared with the transmit-side counter and the message builder.
- Sub-module fix_hb_host_tracker:
  - Per-host FSM, counter, and pending flag/type.
  - Instantiated NUM_HOST times by generate.
- Arbiter and output register live inline in the top.

## Test plan
Common settings: heartbeat_i = 4, GRACE_TICKS = 1 (T = 5), tick_i every 3 cycles.
- Reset: assert rst 3 cycles → all outputs 0. Ticks with no logon → no events.
- Host 1 timeout sequence:
  - Logon host 1, no rx, 5 ticks → evt (TEST_REQ, host 1); ready high.
  - 5 more ticks → evt (DISCONNECT, host 1); dead_mask_o = 0010, active_mask_o = 0000.
- Keep-alive: logon host 0; rx from host 0 every 4 ticks for 60 ticks → no events; active_mask_o = 0001.
- Simultaneous timeouts:
  - Hosts 0, 2, 3 time out on the same tick; ready low 10 cycles → evt (TEST_REQ, 0) held stable.
  - Ready high → events in order 0, 2, 3 on consecutive cycles.
- Race with reply: host 2 in TEST_SENT; rx from host 2 in the same cycle as the tick that makes counter = 5 → state ACTIVE, no DISCONNECT ever issued.
- Disable and reset:
  - heartbeat_i = 0, host 3 logged on, 100 ticks → no events.
  - Then rst while evt_valid_o = 1 → evt_valid_o = 0 next cycle, all masks 0.
